fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register: the producer end of the decode stage's inst_D / PC_plus_4_D interface.
- Consumes the decode stage's resolved branch target and redirect signal.
- Holds the PC and runs a req/ack handshake to a variable-latency instruction memory.
- Absorbs decode stalls with a one-entry hold buffer; squashes wrong-path fetches on redirect. No branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word driven on inst_D for a bubble.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req is high.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- stall_D  in  1  decode cannot accept; IF/ID must hold.
- pc_src_D  in  1  redirect: branch taken or jump, resolved in decode.
- next_br_D  in  32  redirect target from decode.
- inst_D  out  32  IF/ID instruction.
- PC_plus_4_D  out  32  IF/ID PC+4 of inst_D.
- valid_D  out  1  inst_D is a real instruction, not a bubble.

Behaviour:
- Reset:
  - pc_F=RESET_PC, req_addr=RESET_PC, state=S_REQ.
  - inst_D=NOP_INST, PC_plus_4_D=0, valid_D=0, hold buffer empty.
  - imem_req is 0 during the reset cycle and 1 in the first cycle after reset deasserts.
  - Reset mid-transaction abandons any in-flight ack. Memory must not ack in the reset cycle; an ack arriving after reset is treated as a response to the new request.
- imem_req = (state==S_REQ || state==S_KILL). imem_addr = req_addr (registered, bits [1:0] always 00).
- Redirect: a redirect is taken only when pc_src_D=1 and stall_D=0. If both are high, stall wins and pc_src_D is ignored; the hazard unit re-presents the redirect. The target is {next_br_D[31:2],2'b00}.
- States:
  - S_REQ, ack=1, no redirect, stall_D=0: IF/ID <= {imem_rdata, pc_F+4, valid=1}; pc_F, req_addr <= pc_F+4; stay in S_REQ. This gives back-to-back fetch, 1 instruction/cycle with a zero-wait memory.
  - S_REQ, ack=1, stall_D=1: buffer <= {imem_rdata, pc_F+4}; go to S_HOLD. IF/ID holds.
  - S_REQ, ack=0, stall_D=0, no redirect: IF/ID <= bubble (NOP_INST, valid=0; PC_plus_4_D holds).
  - S_REQ, redirect, ack=1: discard rdata; IF/ID <= bubble; pc_F, req_addr <= target; stay in S_REQ.
  - S_REQ, redirect, ack=0: IF/ID <= bubble; pc_F <= target; req_addr unchanged; go to S_KILL.
  - S_KILL: imem_req stays high at the old address until ack. On ack, discard rdata, set req_addr <= pc_F, go to S_REQ. A second redirect while in S_KILL overwrites pc_F only. When stall_D=0, IF/ID loads a bubble.
  - S_HOLD: imem_req=0.
    - If stall_D=1, hold everything.
    - If redirect: drop the buffer; IF/ID <= bubble; pc_F, req_addr <= target; go to S_REQ.
    - Else (stall_D=0): IF/ID <= buffer with valid=1; pc_F, req_addr <= pc_F+4; go to S_REQ.
- In every state, stall_D=1 freezes IF/ID.
- Arithmetic: PC+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- An ack while imem_req=0 is a protocol error: it is ignored and flagged by an assertion.

Decomposition:
- Shared package (fetch_pkg): state encoding (S_REQ=2'd0, S_KILL=2'd1, S_HOLD=2'd2), NOP_INST, RESET_PC default.
- Sub-module if_id_reg: 32+32+1-bit register with synchronous clear (to bubble) and enable (~stall_D), instantiated once.
- FSM, PC and hold buffer remain in fetch_stage.

Test Plan:
1. Reset, then zero-wait memory acking every cycle, returning word=addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8,C. inst_D follows one cycle behind with PC_plus_4_D=4,8,C,10 and valid_D=1 every cycle.
2. Memory with 3-cycle latency -> imem_req held 3 cycles with imem_addr constant. valid_D=0 (NOP_INST) on non-ack cycles; one valid instruction per 3 cycles.
3. stall_D=1 for 4 cycles coincident with an ack at addr 8 -> S_HOLD with imem_req=0 and IF/ID frozen at addr 4's word. After release, inst_D=word(8) with PC_plus_4_D=C, then fetch resumes at C.
4. Redirect with target 32'h0000_0100 while a 3-cycle request to 0x10 is in flight -> imem_addr stays 0x10 until ack, and that data never reaches inst_D. The next request is to 0x100; the first valid inst_D has PC_plus_4_D=0x104.
5. pc_src_D=1 and stall_D=1 together -> no redirect and IF/ID unchanged. The redirect is taken in the first cycle with stall_D=0. next_br_D=32'h0000_0203 -> fetch address 0x200.
6. PC at 32'hFFFF_FFFC fetched -> PC_plus_4_D=0, next imem_addr=0. Reset asserted mid-request -> next request is to RESET_PC with valid_D=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and reset/bubble defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_KILL = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Request/acknowledge bus between the fetch stage and a variable-latency instruction memory.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads an instruction, loads a bubble (clr), or holds when en is low.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  // A bubble keeps the previous PC+4 so only the instruction and valid change.
  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (en) begin
      if (clr) begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end else begin
        inst_d  = inst_in;
        pc4_d   = pc4_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign inst_out  = inst_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, one-entry stall buffer and
// wrong-path squash on decode redirects; feeds the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_stage_if.master         imem,
  input  logic                  stall_D,
  input  logic                  pc_src_D,
  input  logic [31:0]           next_br_D,
  output logic [31:0]           inst_D,
  output logic [31:0]           PC_plus_4_D,
  output logic                  valid_D
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_inst_q, buf_inst_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;

  logic         req;
  logic         ack;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus_4;
  logic         ifid_en;
  logic         ifid_clr;
  logic [31:0]  ifid_inst;
  logic [31:0]  ifid_pc4;

  // Request is suppressed during the reset cycle itself; acks without a request are ignored.
  assign req       = !reset && (state_q == S_REQ || state_q == S_KILL);
  assign ack       = imem.ack && req;
  assign redirect  = pc_src_D && !stall_D;
  assign target    = word_align(next_br_D);
  assign pc_plus_4 = pc_q + 32'd4;

  assign imem.req  = req;
  assign imem.addr = req_addr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_inst_d = buf_inst_q;
    buf_pc4_d  = buf_pc4_q;
    ifid_en    = !stall_D;
    ifid_clr   = 1'b1;
    ifid_inst  = imem.rdata;
    ifid_pc4   = pc_plus_4;
    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = target;
          if (ack) req_addr_d = target;
          else     state_d    = S_KILL;
        end else if (ack) begin
          if (stall_D) begin
            buf_inst_d = imem.rdata;
            buf_pc4_d  = pc_plus_4;
            state_d    = S_HOLD;
          end else begin
            ifid_clr   = 1'b0;
            pc_d       = pc_plus_4;
            req_addr_d = pc_plus_4;
          end
        end
      end
      // The wrong-path request must still complete before the new address can go out.
      S_KILL: begin
        if (redirect) pc_d = target;
        if (ack) begin
          req_addr_d = redirect ? target : pc_q;
          state_d    = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d       = target;
          req_addr_d = target;
          state_d    = S_REQ;
        end else if (!stall_D) begin
          ifid_clr   = 1'b0;
          ifid_inst  = buf_inst_q;
          ifid_pc4   = buf_pc4_q;
          pc_d       = pc_plus_4;
          req_addr_d = pc_plus_4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= word_align(RESET_PC);
      req_addr_q <= word_align(RESET_PC);
      buf_inst_q <= NOP_INST;
      buf_pc4_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_inst_q <= buf_inst_d;
      buf_pc4_q  <= buf_pc4_d;
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk       (clk),
    .reset     (reset),
    .en        (ifid_en),
    .clr       (ifid_clr),
    .inst_in   (ifid_inst),
    .pc4_in    (ifid_pc4),
    .inst_out  (inst_D),
    .pc4_out   (PC_plus_4_D),
    .valid_out (valid_D)
  );

  a_no_ack_without_req: assert property (@(posedge clk) disable iff (reset) !(imem.ack && !imem.req));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a configurable-latency memory model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_D;
  logic        pc_src_D;
  logic [31:0] next_br_D;
  logic [31:0] inst_D;
  logic [31:0] PC_plus_4_D;
  logic        valid_D;

  int checks;
  int failures;
  int mem_lat;
  int mem_cnt;

  localparam logic [31:0] NOP = 32'h0000_0000;

  fetch_stage_if imem ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem.master),
    .stall_D     (stall_D),
    .pc_src_D    (pc_src_D),
    .next_br_D   (next_br_D),
    .inst_D      (inst_D),
    .PC_plus_4_D (PC_plus_4_D),
    .valid_D     (valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory answers mem_lat cycles after a request appears (1 = same cycle).
  always @(negedge clk) begin
    #1;
    if (reset || !imem.req) begin
      imem.ack   = 1'b0;
      imem.rdata = 32'hDEAD_BEEF;
      mem_cnt    = 0;
    end else if (mem_cnt + 1 >= mem_lat) begin
      imem.ack   = 1'b1;
      imem.rdata = word_of(imem.addr);
      mem_cnt    = 0;
    end else begin
      imem.ack   = 1'b0;
      imem.rdata = 32'hDEAD_BEEF;
      mem_cnt    = mem_cnt + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall_D = 1'b0;
    pc_src_D = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mem_lat = 1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem.req); end
    checks++; if (inst_D !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst_D, NOP); end
    checks++; if (PC_plus_4_D !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", PC_plus_4_D); end
    checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_D); end
    checks++; if (imem.addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem.addr); end
    reset = 1'b0;
    #2;
    checks++; if (imem.req !== 1'b1) begin failures++; $display("FAIL post_reset_req got=%0b exp=1", imem.req); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (imem.addr !== 32'(4 * (i + 1))) begin failures++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem.addr, 4 * (i + 1)); end
      checks++; if (inst_D !== word_of(32'(4 * i))) begin failures++; $display("FAIL zw_inst[%0d] got=%h exp=%h", i, inst_D, word_of(32'(4 * i))); end
      checks++; if (PC_plus_4_D !== 32'(4 * (i + 1))) begin failures++; $display("FAIL zw_pc4[%0d] got=%h exp=%h", i, PC_plus_4_D, 4 * (i + 1)); end
      checks++; if (valid_D !== 1'b1) begin failures++; $display("FAIL zw_valid[%0d] got=%0b exp=1", i, valid_D); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] exp_pc4;
    logic [31:0] exp_inst;
    logic        exp_valid;
    mem_lat = 3;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_valid = (k % 3 == 0);
      exp_pc4   = 32'(4 * (k / 3));
      exp_inst  = exp_valid ? word_of(32'(4 * (k / 3 - 1))) : NOP;
      checks++; if (imem.addr !== exp_pc4) begin failures++; $display("FAIL lat_addr[%0d] got=%h exp=%h", k, imem.addr, exp_pc4); end
      checks++; if (imem.req !== 1'b1) begin failures++; $display("FAIL lat_req[%0d] got=%0b exp=1", k, imem.req); end
      checks++; if (valid_D !== exp_valid) begin failures++; $display("FAIL lat_valid[%0d] got=%0b exp=%0b", k, valid_D, exp_valid); end
      checks++; if (inst_D !== exp_inst) begin failures++; $display("FAIL lat_inst[%0d] got=%h exp=%h", k, inst_D, exp_inst); end
      checks++; if (PC_plus_4_D !== exp_pc4) begin failures++; $display("FAIL lat_pc4[%0d] got=%h exp=%h", k, PC_plus_4_D, exp_pc4); end
    end
  endtask

  task automatic test_stall_hold();
    mem_lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem.addr !== 32'h8) begin failures++; $display("FAIL st_pre_addr got=%h exp=8", imem.addr); end
    stall_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL st_req[%0d] got=%0b exp=0", i, imem.req); end
      checks++; if (inst_D !== word_of(32'h4)) begin failures++; $display("FAIL st_inst[%0d] got=%h exp=%h", i, inst_D, word_of(32'h4)); end
      checks++; if (PC_plus_4_D !== 32'h8) begin failures++; $display("FAIL st_pc4[%0d] got=%h exp=8", i, PC_plus_4_D); end
      checks++; if (valid_D !== 1'b1) begin failures++; $display("FAIL st_valid[%0d] got=%0b exp=1", i, valid_D); end
    end
    stall_D = 1'b0;
    @(negedge clk);
    checks++; if (inst_D !== word_of(32'h8)) begin failures++; $display("FAIL st_rel_inst got=%h exp=%h", inst_D, word_of(32'h8)); end
    checks++; if (PC_plus_4_D !== 32'hC) begin failures++; $display("FAIL st_rel_pc4 got=%h exp=C", PC_plus_4_D); end
    checks++; if (imem.addr !== 32'hC || imem.req !== 1'b1) begin failures++; $display("FAIL st_rel_addr got=%h/%0b exp=C/1", imem.addr, imem.req); end
    @(negedge clk);
    checks++; if (inst_D !== word_of(32'hC) || PC_plus_4_D !== 32'h10) begin failures++; $display("FAIL st_resume got=%h/%h exp=%h/10", inst_D, PC_plus_4_D, word_of(32'hC)); end
  endtask

  task automatic test_redirect_kill();
    mem_lat = 1;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (imem.addr !== 32'h10) begin failures++; $display("FAIL rk_pre_addr got=%h exp=10", imem.addr); end
    mem_lat = 3;
    @(negedge clk);
    checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL rk_wait_valid got=%0b exp=0", valid_D); end
    pc_src_D  = 1'b1;
    next_br_D = 32'h0000_0100;
    @(negedge clk);
    checks++; if (imem.addr !== 32'h10 || imem.req !== 1'b1) begin failures++; $display("FAIL rk_kill_addr got=%h/%0b exp=10/1", imem.addr, imem.req); end
    checks++; if (valid_D !== 1'b0) begin failures++; $display("FAIL rk_kill_valid got=%0b exp=0", valid_D); end
    pc_src_D = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (imem.addr !== 32'h100) begin failures++; $display("FAIL rk_new_addr[%0d] got=%h exp=100", i, imem.addr); end
      checks++; if (valid_D !== 1'b0 || inst_D !== NOP) begin failures++; $display("FAIL rk_squash[%0d] got=%0b/%h exp=0/%h", i, valid_D, inst_D, NOP); end
    end
    @(negedge clk);
    checks++; if (valid_D !== 1'b1 || PC_plus_4_D !== 32'h104) begin failures++; $display("FAIL rk_first got=%0b/%h exp=1/104", valid_D, PC_plus_4_D); end
    checks++; if (inst_D !== word_of(32'h100)) begin failures++; $display("FAIL rk_first_inst got=%h exp=%h", inst_D, word_of(32'h100)); end
  endtask

  task automatic test_stall_redirect();
    mem_lat = 1;
    do_reset();
    @(negedge clk);
    stall_D   = 1'b1;
    pc_src_D  = 1'b1;
    next_br_D = 32'h0000_0203;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (inst_D !== word_of(32'h0) || PC_plus_4_D !== 32'h4 || valid_D !== 1'b1) begin failures++; $display("FAIL sr_frozen[%0d] got=%h/%h/%0b exp=%h/4/1", i, inst_D, PC_plus_4_D, valid_D, word_of(32'h0)); end
      checks++; if (imem.req !== 1'b0) begin failures++; $display("FAIL sr_req[%0d] got=%0b exp=0", i, imem.req); end
    end
    stall_D = 1'b0;
    @(negedge clk);
    checks++; if (imem.addr !== 32'h200) begin failures++; $display("FAIL sr_addr got=%h exp=200", imem.addr); end
    checks++; if (valid_D !== 1'b0 || PC_plus_4_D !== 32'h4) begin failures++; $display("FAIL sr_bubble got=%0b/%h exp=0/4", valid_D, PC_plus_4_D); end
    pc_src_D = 1'b0;
    @(negedge clk);
    checks++; if (inst_D !== word_of(32'h200) || PC_plus_4_D !== 32'h204) begin failures++; $display("FAIL sr_target got=%h/%h exp=%h/204", inst_D, PC_plus_4_D, word_of(32'h200)); end
  endtask

  task automatic test_wrap_and_reset();
    mem_lat = 1;
    do_reset();
    pc_src_D  = 1'b1;
    next_br_D = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++; if (imem.addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_addr got=%h exp=FFFFFFFC", imem.addr); end
    pc_src_D = 1'b0;
    @(negedge clk);
    checks++; if (PC_plus_4_D !== 32'h0 || valid_D !== 1'b1) begin failures++; $display("FAIL wr_pc4 got=%h/%0b exp=0/1", PC_plus_4_D, valid_D); end
    checks++; if (inst_D !== 32'h5A5A_FFFC) begin failures++; $display("FAIL wr_inst got=%h exp=5A5AFFFC", inst_D); end
    checks++; if (imem.addr !== 32'h0) begin failures++; $display("FAIL wr_next_addr got=%h exp=0", imem.addr); end
    @(negedge clk);
    mem_lat = 3;
    @(negedge clk);
    checks++; if (imem.addr !== 32'h4 || imem.req !== 1'b1) begin failures++; $display("FAIL mr_inflight got=%h/%0b exp=4/1", imem.addr, imem.req); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (imem.addr !== 32'h0 || valid_D !== 1'b0 || PC_plus_4_D !== 32'h0) begin failures++; $display("FAIL mr_reset got=%h/%0b/%h exp=0/0/0", imem.addr, valid_D, PC_plus_4_D); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (valid_D !== 1'b0 || imem.addr !== 32'h0) begin failures++; $display("FAIL mr_wait[%0d] got=%0b/%h exp=0/0", i, valid_D, imem.addr); end
    end
    @(negedge clk);
    checks++; if (valid_D !== 1'b1 || inst_D !== word_of(32'h0) || PC_plus_4_D !== 32'h4) begin failures++; $display("FAIL mr_first got=%0b/%h/%h exp=1/%h/4", valid_D, inst_D, PC_plus_4_D, word_of(32'h0)); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    mem_lat    = 1;
    mem_cnt    = 0;
    reset      = 1'b1;
    stall_D    = 1'b0;
    pc_src_D   = 1'b0;
    next_br_D  = 32'h0;
    imem.ack   = 1'b0;
    imem.rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_redirect_kill();
    test_stall_redirect();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
